// File: rtl/weight_streamer_pkg.sv
// weight_streamer_pkg: FSM encoding and default parameters shared by the weight streamer.
package weight_streamer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int COEFF_W_DEF = 16;
  localparam int DEPTH_DEF = 9;
  localparam int LANES_DEF = 1;
  localparam int REPEAT_DEF = 1;
  localparam string MEM_FILE_DEF = "./conv_0_weight.mem";
endpackage

// File: rtl/rom.sv
// rom: synchronous-read ROM with one-cycle latency.
module rom #(
  parameter int mem_size = 9,
  parameter int data_width = 16,
  parameter string mem_file = ""
) (
  input  logic                        clk,
  input  logic [$clog2(mem_size)-1:0] addr,
  output logic [data_width-1:0]       q
);
  logic [data_width-1:0] mem [mem_size];
  always_ff @(posedge clk) q <= mem[addr];
endmodule

// File: rtl/weight_streamer.sv
// weight_streamer: streams ROM words REPEAT times per ap_start through a 2-entry skid FIFO.
// Optional WEIGHT_STREAM_CHKSUM_EN adds a per-job 32-bit wrapping checksum of written words.
module weight_streamer
  import weight_streamer_pkg::*;
#(
  parameter int COEFF_W = COEFF_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LANES = LANES_DEF,
  parameter int REPEAT = REPEAT_DEF,
  parameter string MEM_FILE = MEM_FILE_DEF
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic                       ap_start,
  output logic                       ap_idle,
  output logic                       ap_done,
  output logic [COEFF_W*LANES-1:0]   output_V_din,
  input  logic                       output_V_full_n,
  output logic                       output_V_write
`ifdef WEIGHT_STREAM_CHKSUM_EN
  ,
  output logic [31:0]                chksum
`endif
);
  localparam int W = COEFF_W * LANES;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(REPEAT + 1);
  state_t state, state_n;
  logic [AW-1:0] addr;
  logic [PW-1:0] pass;
  logic inflight, pop, issue, wrap, last_rd, fin, wp, rp;
  logic [1:0] cnt, occ;
  logic [W-1:0] q;
  logic [W-1:0] e [2];
  rom #(.mem_size(DEPTH), .data_width(W), .mem_file(MEM_FILE)) u_rom (
    .clk(ap_clk),
    .addr(addr),
    .q(q)
  );
  // Read issue only looks at registered occupancy plus this cycle's pop, so two slots always suffice.
  always_comb begin
    pop = cnt != 2'd0 && output_V_full_n && !ap_rst;
    occ = cnt + {1'b0, inflight} - {1'b0, pop};
    issue = state == RUN && occ < 2'd2;
    wrap = addr == AW'(DEPTH - 1);
    last_rd = issue && wrap && pass == PW'(REPEAT - 1);
    fin = state == DRAIN && pop && cnt == 2'd1 && !inflight;
    state_n = state == IDLE && ap_start ? RUN : last_rd ? DRAIN : fin ? IDLE : state;
  end
  always_ff @(posedge ap_clk) state <= ap_rst ? IDLE : state_n;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      addr <= '0;
      pass <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) addr <= wrap ? '0 : addr + 1'b1;
      if (issue && wrap) pass <= pass == PW'(REPEAT - 1) ? '0 : pass + 1'b1;
    end
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      e[0] <= '0;
      e[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      ap_done <= 1'b0;
    end else begin
      if (inflight) e[wp] <= q;
      if (inflight) wp <= ~wp;
      if (pop) rp <= ~rp;
      cnt <= occ;
      ap_done <= fin;
    end
  end
  assign ap_idle = state == IDLE;
  assign output_V_write = pop;
  assign output_V_din = e[rp];
`ifdef WEIGHT_STREAM_CHKSUM_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst || (state == IDLE && ap_start)) chksum <= '0;
    else if (pop) chksum <= chksum + 32'(output_V_din);
  end
`endif
endmodule

// File: tb/tb_weight_streamer.sv
// tb_weight_streamer: directed checks of the weight streamer (timing, repeat, backpressure, abort, random stalls).
module tb_weight_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, s1, f1, s3, f3, idle1, done1, wr1, idle3, done3, wr3;
  logic [31:0] din1, din3;
`ifdef WEIGHT_STREAM_CHKSUM_EN
  logic [31:0] ck1, ck3;
`endif
  int vecs = 0;
  int errs = 0;
  weight_streamer #(.COEFF_W(16), .DEPTH(9), .LANES(2), .REPEAT(1), .MEM_FILE("")) d1 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(s1), .ap_idle(idle1), .ap_done(done1),
    .output_V_din(din1), .output_V_full_n(f1), .output_V_write(wr1)
`ifdef WEIGHT_STREAM_CHKSUM_EN
    , .chksum(ck1)
`endif
  );
  weight_streamer #(.COEFF_W(16), .DEPTH(9), .LANES(2), .REPEAT(3), .MEM_FILE("")) d3 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(s3), .ap_idle(idle3), .ap_done(done3),
    .output_V_din(din3), .output_V_full_n(f3), .output_V_write(wr3)
`ifdef WEIGHT_STREAM_CHKSUM_EN
    , .chksum(ck3)
`endif
  );
  function automatic logic [31:0] word(input int k);
    return {16'(k + 100), 16'(k)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    int idx, dn, ok;
    bit we;
    rst = 1'b1; s1 = 1'b0; s3 = 1'b0; f1 = 1'b1; f3 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      d1.u_rom.mem[k] = word(k);
      d3.u_rom.mem[k] = word(k);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_idle", 64'(idle1), 64'd1);
    chk("rst_done", 64'(done1), 64'd0);
    chk("rst_write", 64'(wr1), 64'd0);
    chk("rst_din", 64'(din1), 64'd0);
    // single pass: writes in t+3..t+11, done in t+12
    @(negedge clk); rst = 1'b0; s1 = 1'b1; #1;
    chk("t0_idle", 64'(idle1), 64'd1);
    @(negedge clk); s1 = 1'b0; #1;
    chk("t1_idle", 64'(idle1), 64'd0);
    chk("t1_write", 64'(wr1), 64'd0);
    @(negedge clk); #1;
    chk("t2_write", 64'(wr1), 64'd0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); #1;
      chk("pass_write", 64'(wr1), 64'd1);
      chk("pass_din", 64'(din1), 64'(word(k)));
    end
    @(negedge clk); #1;
    chk("end_write", 64'(wr1), 64'd0);
    chk("end_done", 64'(done1), 64'd1);
    chk("end_idle", 64'(idle1), 64'd1);
`ifdef WEIGHT_STREAM_CHKSUM_EN
    chk("chksum", 64'(ck1), 64'd61341732);
`endif
    @(negedge clk); #1;
    chk("done_pulse", 64'(done1), 64'd0);
`ifdef WEIGHT_STREAM_CHKSUM_EN
    chk("chksum_hold", 64'(ck1), 64'd61341732);
`endif
    // backpressure from the 4th word for 10 cycles
    @(negedge clk); s1 = 1'b1; #1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk); s1 = 1'b0; f1 = (c >= 6 && c <= 15) ? 1'b0 : 1'b1; #1;
      we = (c >= 3 && c <= 5) || (c >= 16 && c <= 21);
      chk("bp_write", 64'(wr1), 64'(we));
      if (c >= 3 && c <= 21) chk("bp_din", 64'(din1), 64'(word(c <= 5 ? c - 3 : c <= 15 ? 3 : c - 13)));
      if (c == 22) chk("bp_done", 64'(done1), 64'd1);
    end
    // reset in the cycle after the 5th write aborts the job
    @(negedge clk); f1 = 1'b1; s1 = 1'b1; #1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); s1 = 1'b0; rst = (c == 8); #1;
      if (c >= 3 && c <= 7) chk("ab_din", 64'(din1), 64'(word(c - 3)));
      if (c == 8) chk("ab_write", 64'(wr1), 64'd0);
    end
    @(negedge clk); rst = 1'b0; #1;
    chk("ab_idle", 64'(idle1), 64'd1);
    dn = int'(done1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      dn += int'(done1);
    end
    chk("ab_nodone", 64'(dn), 64'd0);
    @(negedge clk); s1 = 1'b1; #1;
    @(negedge clk); s1 = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("ab_restart_wr", 64'(wr1), 64'd1);
    chk("ab_restart_din", 64'(din1), 64'(word(0)));
    // a start mid-job is ignored and not queued
    idx = 1; ok = 0;
    for (int c = 0; c < 40 && ok == 0; c++) begin
      @(negedge clk); s1 = (c == 2); #1;
      idx += int'(wr1);
      ok = int'(done1);
    end
    chk("ign_count", 64'(idx), 64'd9);
    chk("ign_done", 64'(ok), 64'd1);
    dn = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); #1;
      dn += int'(wr1);
    end
    chk("ign_noqueue", 64'(dn), 64'd0);
    // three passes: 27 contiguous writes, one ap_done
    @(negedge clk); s3 = 1'b1; #1;
    dn = 0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk); s3 = 1'b0; #1;
      chk("rep_write", 64'(wr3), 64'(c >= 3 && c <= 29));
      if (c >= 3 && c <= 29) chk("rep_din", 64'(din3), 64'(word((c - 3) % 9)));
      if (c == 30) chk("rep_done_cyc", 64'(done3), 64'd1);
      dn += int'(done3);
    end
    chk("rep_done_cnt", 64'(dn), 64'd1);
    // random backpressure scoreboard
    for (int j = 0; j < 1000; j++) begin
      @(negedge clk); s1 = 1'b1; f1 = 1'($urandom_range(0, 1)); #1;
      idx = 0; ok = 0;
      for (int c = 0; c < 300 && ok == 0; c++) begin
        @(negedge clk); s1 = 1'b0; f1 = 1'($urandom_range(0, 1)); #1;
        if (wr1) begin
          chk("rnd_din", 64'(din1), 64'(word(idx)));
          idx++;
        end
        ok = int'(done1);
      end
      chk("rnd_count", 64'(idx), 64'd9);
      chk("rnd_done", 64'(ok), 64'd1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
